// File: rtl/servo_pkg.sv
// servo_pkg: shared widths, FSM states and duty-range defaults for the servo PWM chain
package servo_pkg;
  localparam int DUTY_W = 4;
  localparam int DUTY_MIN_DEF = 0;
  localparam int DUTY_MAX_DEF = 15;
  typedef logic [DUTY_W-1:0] duty_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;
  function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction
endpackage

// File: rtl/servo_duty_ramp_if.sv
// servo_duty_ramp_if: switch input and duty/target/busy outputs of the ramp stage
//   sw     raw slide switches (driven by master)
//   duty   slewed duty command, target: debounced clamped setpoint, busy: duty != target
interface servo_duty_ramp_if;
  import servo_pkg::*;
  duty_t sw;
  duty_t duty;
  duty_t target;
  logic busy;
  modport master(output sw, input duty, target, busy);
  modport slave(input sw, output duty, target, busy);
endinterface

// File: rtl/servo_duty_ramp_debounce.sv
// sw_debounce: 2-FF synchroniser plus stable-for-DB_CYCLES debounce with one-shot accept strobe
//   clk, rst_n   clock, async active-low reset
//   sw_i         raw asynchronous input
//   val_o        accepted (debounced) value, valid when stb_o
//   stb_o        single-cycle strobe when a value becomes accepted
module sw_debounce #(
  parameter int WIDTH = 4,
  parameter int DB_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] val_o,
  output logic             stb_o
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  logic [WIDTH-1:0] s1_q, s2_q, cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic held_q, held_d, diff, sat;
  always_comb begin
    diff = s2_q != cand_q;
    sat = cnt_q == CW'(DB_CYCLES - 1);
    cand_d = diff ? s2_q : cand_q;
    cnt_d = diff ? '0 : sat ? cnt_q : cnt_q + CW'(1);
    stb_o = !diff && sat && !held_q;
    // held suppresses repeat strobes while the counter sits saturated
    held_d = diff ? 1'b0 : (held_q | stb_o);
    val_o = cand_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      held_q <= 1'b0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      held_q <= held_d;
    end
  end
endmodule

// File: rtl/servo_duty_ramp.sv
// servo_duty_ramp: debounces and clamps the switch setpoint and slews duty one LSB per step tick
//   clk, rst_n   clock, async active-low reset
//   bus.sw       raw switches in; bus.duty / bus.target / bus.busy out
module servo_duty_ramp
  import servo_pkg::*;
#(
  parameter int DB_CYCLES = 500_000,
  parameter int STEP_CYCLES = 5_000_000,
  parameter int DUTY_MIN = DUTY_MIN_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input logic clk,
  input logic rst_n,
  servo_duty_ramp_if.slave bus
);
  localparam int TW = $clog2(STEP_CYCLES);
  localparam duty_t LO = duty_t'(DUTY_MIN);
  localparam duty_t HI = duty_t'(DUTY_MAX);
  duty_t acc, target_q, target_d, duty_q, duty_d;
  logic acc_stb, tick;
  logic [TW-1:0] tmr_q, tmr_d;
  state_e state_q, state_d;
  sw_debounce #(.WIDTH(DUTY_W), .DB_CYCLES(DB_CYCLES)) u_db (
    .clk(clk),
    .rst_n(rst_n),
    .sw_i(bus.sw),
    .val_o(acc),
    .stb_o(acc_stb)
  );
  always_comb begin
    tick = tmr_q == TW'(STEP_CYCLES - 1);
    tmr_d = tick ? '0 : tmr_q + TW'(1);
    target_d = acc_stb ? clamp_duty(acc, LO, HI) : target_q;
    // direction comes from the registered target, so a same-cycle target change waits a tick
    state_d = (duty_q < target_q) ? UP : (duty_q > target_q) ? DOWN : IDLE;
    duty_d = (tick && state_d == UP) ? duty_q + duty_t'(1) :
             (tick && state_d == DOWN) ? duty_q - duty_t'(1) : duty_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= LO;
      duty_q <= LO;
      tmr_q <= '0;
      state_q <= IDLE;
    end else begin
      target_q <= target_d;
      duty_q <= duty_d;
      tmr_q <= tmr_d;
      state_q <= state_d;
    end
  end
  assign bus.duty = duty_q;
  assign bus.target = target_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_servo_duty_ramp.sv
// tb_servo_duty_ramp: directed stimulus against a run-length/arithmetic model of two ramp instances
module tb_servo_duty_ramp;
  import servo_pkg::*;
  localparam int DB = 4;
  localparam int STEP = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sw = 4'hF;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  servo_duty_ramp_if if0();
  servo_duty_ramp_if if1();
  assign if0.sw = sw;
  assign if1.sw = sw;
  servo_duty_ramp #(.DB_CYCLES(DB), .STEP_CYCLES(STEP)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  servo_duty_ramp #(.DB_CYCLES(DB), .STEP_CYCLES(STEP), .DUTY_MIN(2), .DUTY_MAX(10)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic int lo(input int i);
    return i ? 2 : 0;
  endfunction
  function automatic int hi(input int i);
    return i ? 10 : 15;
  endfunction
  function automatic int dut_duty(input int w);
    return w ? int'(if1.duty) : int'(if0.duty);
  endfunction
  // model: sw_s is sw two samples late; a value is accepted once sw_s has shown it DB+1 times in a row
  int m_duty[2], m_tgt[2], m_busy[2];
  int s1, ss, val, run, mcyc;
  bit m_tick;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 = 0; ss = 0; val = 0; run = 2; mcyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_duty[i] = lo(i); m_tgt[i] = lo(i); m_busy[i] = 0;
      end
    end else begin
      m_tick = (mcyc % STEP) == STEP - 1;
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = int'(m_duty[i] != m_tgt[i]);
        if (m_tick && m_duty[i] < m_tgt[i]) m_duty[i]++;
        else if (m_tick && m_duty[i] > m_tgt[i]) m_duty[i]--;
        if (run > DB) m_tgt[i] = (val < lo(i)) ? lo(i) : (val > hi(i)) ? hi(i) : val;
      end
      ss = s1;
      s1 = int'(sw);
      if (ss == val) begin
        if (run < 1000) run++;
      end else begin
        val = ss; run = 1;
      end
      mcyc++;
    end
  end
  always @(negedge clk) begin
    chk("model duty0", int'(if0.duty), m_duty[0]);
    chk("model target0", int'(if0.target), m_tgt[0]);
    chk("model busy0", int'(if0.busy), m_busy[0]);
    chk("model duty1", int'(if1.duty), m_duty[1]);
    chk("model target1", int'(if1.target), m_tgt[1]);
    chk("model busy1", int'(if1.busy), m_busy[1]);
  end
  task automatic wait_change(input int w, input int budget, output int nv);
    int old, k;
    old = dut_duty(w);
    k = 0;
    while (dut_duty(w) == old && k < budget) begin
      @(negedge clk);
      k++;
    end
    nv = dut_duty(w);
  endtask
  task automatic wait_until(input int w, input int v, input int budget, input string n);
    int k;
    k = 0;
    while (dut_duty(w) != v && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(n, dut_duty(w), v);
  endtask
  initial begin
    int nv, t_prev;
    t_prev = 0;
    repeat (3) @(negedge clk);
    chk("rst duty0", int'(if0.duty), 0);
    chk("rst target0", int'(if0.target), 0);
    chk("rst busy0", int'(if0.busy), 0);
    chk("rst duty1", int'(if1.duty), 2);
    sw = 4'h0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle duty0", int'(if0.duty), 0);
    chk("idle target0", int'(if0.target), 0);
    chk("idle busy0", int'(if0.busy), 0);
    sw = 4'h5;
    repeat (6) @(negedge clk);
    chk("target early", int'(if0.target), 0);
    @(negedge clk);
    chk("target at 7", int'(if0.target), 5);
    for (int k = 1; k <= 5; k++) begin
      wait_change(0, 20, nv);
      chk("ramp step", nv, k);
      chk("ramp busy", int'(if0.busy), 1);
      if (k > 1) chk("ramp period", cyc - t_prev, STEP);
      t_prev = cyc;
    end
    @(negedge clk);
    chk("busy after settle", int'(if0.busy), 0);
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2) ? 4'h5 : 4'h6;
      repeat (2) @(negedge clk);
    end
    chk("bounce hold", int'(if0.target), 5);
    sw = 4'h6;
    repeat (6) @(negedge clk);
    chk("bounce stable early", int'(if0.target), 5);
    @(negedge clk);
    chk("bounce accept", int'(if0.target), 6);
    wait_until(0, 6, 30, "settle 6");
    sw = 4'hC;
    wait_until(0, 7, 60, "reach 7");
    sw = 4'h3;
    wait_change(0, 20, nv);
    chk("reversal first", nv, 6);
    for (int v = 5; v >= 3; v--) begin
      wait_change(0, 20, nv);
      chk("reverse ramp", nv, v);
    end
    sw = 4'hF;
    wait_until(1, 10, 300, "clamp hi duty1");
    chk("clamp hi target1", int'(if1.target), 10);
    repeat (24) @(negedge clk);
    chk("clamp hi hold1", int'(if1.duty), 10);
    chk("unclamped target0", int'(if0.target), 15);
    sw = 4'h0;
    wait_until(1, 2, 300, "clamp lo duty1");
    chk("clamp lo target1", int'(if1.target), 2);
    repeat (24) @(negedge clk);
    chk("clamp lo hold1", int'(if1.duty), 2);
    sw = 4'hF;
    wait_until(0, 9, 400, "reach 9");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async duty0", int'(if0.duty), 0);
    chk("async busy0", int'(if0.busy), 0);
    chk("async target0", int'(if0.target), 0);
    chk("async duty1", int'(if1.duty), 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_change(0, 60, nv);
    chk("restart step", nv, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
